// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer driving an external PC register.
// Optional interrupt entry on the PC update is enabled with macro IRQ_EN.
module fetch_sequencer #(
    parameter logic [7:0]  RESET_VECTOR  = 8'h00,
    parameter logic [7:0]  IRQ_VECTOR    = 8'hF0,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       halt_req,
    input  logic       mem_ready,
    input  logic [7:0] instr,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    input  logic [7:0] pc_value,
    input  logic       irq,
    output logic       pc_load,
    output logic [7:0] pc_in,
    output logic       mem_req,
    output logic [7:0] ir,
    output logic       exec_valid,
    output logic       halted,
    output logic       fault,
    output logic       irq_ack,
    output logic [7:0] epc
);

    localparam int unsigned CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_DECODE  = 3'd3;
    localparam logic [2:0] S_EXECUTE = 3'd4;
    localparam logic [2:0] S_UPDATE  = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;
    localparam logic [2:0] S_FAULT   = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ir_d, pc_in_d, epc_d, next_pc;
    logic             pc_load_d, mem_req_d, exec_valid_d, halted_d, fault_d, irq_ack_d;

    assign next_pc = branch_taken ? branch_target : pc_value + 8'd1;

`ifndef IRQ_EN
    logic unused_irq;
    assign unused_irq = irq ^ (^IRQ_VECTOR);
`endif

    // Next state plus registered outputs decoded from the state being entered,
    // so each strobe is high exactly while the FSM occupies its state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ir_d         = ir;
        pc_in_d      = pc_in;
        epc_d        = epc;
        pc_load_d    = 1'b0;
        mem_req_d    = 1'b0;
        exec_valid_d = 1'b0;
        halted_d     = 1'b0;
        fault_d      = 1'b0;
        irq_ack_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                state_d = (ir == 8'hFF) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                // Branch (and irq) are sampled here so the UPDATE load value is registered.
                state_d = S_UPDATE;
                pc_in_d = next_pc;
`ifdef IRQ_EN
                if (irq) begin
                    pc_in_d   = IRQ_VECTOR;
                    epc_d     = next_pc;
                    irq_ack_d = 1'b1;
                end
`endif
            end
            S_UPDATE: begin
                state_d = halt_req ? S_HALT : S_FETCH;
                cnt_d   = '0;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        case (state_d)
            S_INIT: begin
                pc_load_d = 1'b1;
                pc_in_d   = RESET_VECTOR;
            end
            S_FETCH:   mem_req_d    = 1'b1;
            S_EXECUTE: exec_valid_d = 1'b1;
            S_UPDATE:  pc_load_d    = 1'b1;
            S_HALT:    halted_d     = 1'b1;
            S_FAULT:   fault_d      = 1'b1;
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pc_load    <= 1'b0;
            pc_in      <= 8'h00;
            mem_req    <= 1'b0;
            ir         <= 8'h00;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            irq_ack    <= 1'b0;
            epc        <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_load    <= pc_load_d;
            pc_in      <= pc_in_d;
            mem_req    <= mem_req_d;
            ir         <= ir_d;
            exec_valid <= exec_valid_d;
            halted     <= halted_d;
            fault      <= fault_d;
            irq_ack    <= irq_ack_d;
            epc        <= epc_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: instruction-level reference builds an expected per-cycle
// trace from a scenario description; one process compares the DUT against it every cycle.
module tb_fetch_sequencer;

    localparam logic [7:0] RV   = 8'h00;
    localparam logic [7:0] IV   = 8'hF0;
    localparam int         TO   = 15;
    localparam int         MAXC = 256;
    localparam int         MAXI = 8;

    typedef struct packed {
        logic       reset;
        logic       start;
        logic       halt_req;
        logic       mem_ready;
        logic [7:0] instr;
        logic       branch_taken;
        logic [7:0] branch_target;
        logic [7:0] pc_value;
        logic       irq;
    } stim_t;

    typedef struct packed {
        logic       pc_load;
        logic [7:0] pc_in;
        logic       mem_req;
        logic [7:0] ir;
        logic       exec_valid;
        logic       halted;
        logic       fault;
        logic       irq_ack;
        logic [7:0] epc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0, start = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
    logic [7:0] instr = 8'h00, branch_target = 8'h00, pc_value = 8'h00;
    logic branch_taken = 1'b0, irq = 1'b0;
    logic pc_load, mem_req, exec_valid, halted, fault, irq_ack;
    logic [7:0] pc_in, ir, epc;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_VECTOR(RV), .IRQ_VECTOR(IV), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .mem_ready(mem_ready), .instr(instr), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc_value(pc_value), .irq(irq),
        .pc_load(pc_load), .pc_in(pc_in), .mem_req(mem_req), .ir(ir),
        .exec_valid(exec_valid), .halted(halted), .fault(fault),
        .irq_ack(irq_ack), .epc(epc)
    );

    stim_t st[MAXC];
    exp_t  ex[MAXC];
    int    plen;

    // scenario description
    logic [7:0] i_op[MAXI], i_tg[MAXI];
    int         i_wt[MAXI];
    logic       i_br[MAXI], i_hq[MAXI], i_irq[MAXI];
    int         n_instr, n_idle, rst_at;

    // reference model state
    logic [7:0] pc_in_h, ir_h, epc_h, pcr;
    int         k;

    int total = 0, bad = 0;
    int cur = 0;
    bit active = 1'b0;
    logic [7:0] loads_q[$];
    int lcyc_q[$];
    int exec_n, ack_n, fault_cyc, halt_seen;
    logic [7:0] wl[8];
    int wn;

    task automatic chk(input string nm, input int cyc, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    function automatic exp_t hold_exp();
        exp_t e;
        e = '0;
        e.pc_in = pc_in_h;
        e.ir    = ir_h;
        e.epc   = epc_h;
        return e;
    endfunction

    task automatic put(input exp_t e);
        if (k < MAXC - 1) begin
            ex[k] = e;
            k++;
            st[k].pc_value = pcr;
        end
    endtask

    task automatic tail(input bit is_fault);
        exp_t e;
        repeat (4) begin
            e = hold_exp();
            if (is_fault) e.fault = 1'b1;
            else e.halted = 1'b1;
            put(e);
        end
    endtask

    // Walk the scenario one instruction at a time and lay out the cycle trace.
    task automatic build();
        exp_t e;
        bit done;
        logic [7:0] nxt;
        for (int i = 0; i < MAXC; i++) begin
            st[i].reset         = 1'b0;
            st[i].start         = 1'($urandom);
            st[i].halt_req      = 1'($urandom);
            st[i].mem_ready     = 1'($urandom);
            st[i].instr         = 8'($urandom);
            st[i].branch_taken  = 1'($urandom);
            st[i].branch_target = 8'($urandom);
            st[i].pc_value      = 8'($urandom);
            st[i].irq           = 1'($urandom);
        end
        i_hq[n_instr-1] = 1'b1;
        k = 0; pc_in_h = 8'h00; ir_h = 8'h00; epc_h = 8'h00; pcr = 8'h00;
        st[0].reset = 1'b1;
        put(hold_exp());
        repeat (n_idle) begin
            st[k].start = 1'b0;
            put(hold_exp());
        end
        st[k].start = 1'b1;
        pc_in_h = RV;
        e = hold_exp(); e.pc_load = 1'b1;
        put(e);
        pcr = RV;
        done = 1'b0;
        for (int j = 0; j < n_instr && !done; j++) begin
            if (i_wt[j] >= TO) begin
                for (int w = 0; w < TO; w++) begin
                    e = hold_exp(); e.mem_req = 1'b1; put(e);
                    st[k].mem_ready = 1'b0;
                end
                tail(1'b1);
                done = 1'b1;
                break;
            end
            for (int w = 0; w <= i_wt[j]; w++) begin
                e = hold_exp(); e.mem_req = 1'b1; put(e);
                st[k].mem_ready = (w == i_wt[j]);
                if (w == i_wt[j]) st[k].instr = i_op[j];
            end
            ir_h = i_op[j];
            put(hold_exp());
            if (i_op[j] == 8'hFF) begin
                tail(1'b0);
                done = 1'b1;
                break;
            end
            e = hold_exp(); e.exec_valid = 1'b1; put(e);
            if (rst_at == j) begin
                st[k].reset = 1'b1;
                pc_in_h = 8'h00; ir_h = 8'h00; epc_h = 8'h00;
                put(hold_exp());
                repeat (3) begin
                    st[k].start = 1'b0;
                    put(hold_exp());
                end
                done = 1'b1;
                break;
            end
            st[k].branch_taken  = i_br[j];
            st[k].branch_target = i_tg[j];
            st[k].irq           = i_irq[j];
            nxt = i_br[j] ? i_tg[j] : pcr + 8'd1;
            e = hold_exp();
`ifdef IRQ_EN
            if (i_irq[j]) begin
                epc_h = nxt; pc_in_h = IV; e.irq_ack = 1'b1;
            end else pc_in_h = nxt;
`else
            pc_in_h = nxt;
`endif
            e.pc_in = pc_in_h; e.epc = epc_h; e.pc_load = 1'b1;
            put(e);
            pcr = pc_in_h;
            st[k].halt_req = i_hq[j];
            if (i_hq[j]) begin
                tail(1'b0);
                done = 1'b1;
            end
        end
        plen = k;
    endtask

    task automatic run_plan();
        loads_q.delete(); lcyc_q.delete();
        exec_n = 0; ack_n = 0; fault_cyc = -1; halt_seen = 0;
        for (int c = 0; c < plen; c++) begin
            @(negedge clk);
            reset = st[c].reset; start = st[c].start; halt_req = st[c].halt_req;
            mem_ready = st[c].mem_ready; instr = st[c].instr;
            branch_taken = st[c].branch_taken; branch_target = st[c].branch_target;
            pc_value = st[c].pc_value; irq = st[c].irq;
            cur = c;
            active = 1'b1;
        end
        @(negedge clk);
        active = 1'b0;
    endtask

    // Per-cycle comparison against the reference trace.
    always @(posedge clk) begin
        if (active) begin
            #1;
            chk("pc_load",    cur, 8'(pc_load),    8'(ex[cur].pc_load));
            chk("pc_in",      cur, pc_in,          ex[cur].pc_in);
            chk("mem_req",    cur, 8'(mem_req),    8'(ex[cur].mem_req));
            chk("ir",         cur, ir,             ex[cur].ir);
            chk("exec_valid", cur, 8'(exec_valid), 8'(ex[cur].exec_valid));
            chk("halted",     cur, 8'(halted),     8'(ex[cur].halted));
            chk("fault",      cur, 8'(fault),      8'(ex[cur].fault));
            chk("irq_ack",    cur, 8'(irq_ack),    8'(ex[cur].irq_ack));
            chk("epc",        cur, epc,            ex[cur].epc);
            if (pc_load) begin loads_q.push_back(pc_in); lcyc_q.push_back(cur); end
            if (exec_valid) exec_n++;
            if (irq_ack) ack_n++;
            if (halted) halt_seen = 1;
            if (fault && fault_cyc < 0) fault_cyc = cur;
        end
    end

    task automatic check_loads(input string nm);
        chk({nm, "_nloads"}, -1, 8'(loads_q.size()), 8'(wn));
        for (int i = 0; i < wn && i < loads_q.size(); i++)
            chk({nm, "_load"}, i, loads_q[i], wl[i]);
    endtask

    task automatic set_instr(input int j, input logic [7:0] op, input int wt,
                             input logic br, input logic [7:0] tg, input logic hq, input logic iq);
        i_op[j] = op; i_wt[j] = wt; i_br[j] = br; i_tg[j] = tg; i_hq[j] = hq; i_irq[j] = iq;
    endtask

    initial begin
        // A: straight-line, loads 00,01,02,03 every 4 cycles
        n_idle = 2; n_instr = 3; rst_at = -1;
        for (int j = 0; j < 3; j++) set_instr(j, 8'h10, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        build(); run_plan();
        wn = 4; wl[0] = 8'h00; wl[1] = 8'h01; wl[2] = 8'h02; wl[3] = 8'h03;
        check_loads("A");
        for (int i = 1; i < lcyc_q.size(); i++) chk("A_spacing", i, 8'(lcyc_q[i] - lcyc_q[i-1]), 8'd4);
        chk("A_exec_count", -1, 8'(exec_n), 8'd3);
        chk("A_halted", -1, 8'(halt_seen), 8'd1);

        // B: branches, 8'hFF wrap, irq on final update
        n_idle = 0; n_instr = 6; rst_at = -1;
        set_instr(0, 8'h21, 0, 1'b1, 8'h7C, 1'b0, 1'b0);
        set_instr(1, 8'h22, 1, 1'b1, 8'h20, 1'b0, 1'b0);
        set_instr(2, 8'h23, 0, 1'b1, 8'hFF, 1'b0, 1'b0);
        set_instr(3, 8'h24, 2, 1'b0, 8'h99, 1'b0, 1'b0);
        set_instr(4, 8'h25, 0, 1'b1, 8'h05, 1'b0, 1'b0);
        set_instr(5, 8'h26, 0, 1'b0, 8'h99, 1'b1, 1'b1);
        build(); run_plan();
        wn = 7; wl[0] = 8'h00; wl[1] = 8'h7C; wl[2] = 8'h20; wl[3] = 8'hFF; wl[4] = 8'h00; wl[5] = 8'h05;
`ifdef IRQ_EN
        wl[6] = 8'hF0;
        chk("B_ack_count", -1, 8'(ack_n), 8'd1);
        chk("B_epc", -1, epc, 8'h06);
`else
        wl[6] = 8'h06;
        chk("B_ack_count", -1, 8'(ack_n), 8'd0);
        chk("B_epc", -1, epc, 8'h00);
`endif
        check_loads("B");

        // C: fetch timeout after 15 waiting cycles
        n_idle = 1; n_instr = 1; rst_at = -1;
        set_instr(0, 8'h10, TO, 1'b0, 8'h00, 1'b1, 1'b0);
        build(); run_plan();
        wn = 1; wl[0] = 8'h00;
        check_loads("C");
        if (lcyc_q.size() > 0) chk("C_fault_delay", fault_cyc, 8'(fault_cyc - lcyc_q[0]), 8'd16);
        else chk("C_fault_delay", fault_cyc, 8'hEE, 8'd16);

        // D: mem_ready on the last allowed fetch cycle, then HLT
        n_idle = 0; n_instr = 2; rst_at = -1;
        set_instr(0, 8'h10, TO - 1, 1'b0, 8'h00, 1'b0, 1'b0);
        set_instr(1, 8'hFF, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        build(); run_plan();
        wn = 2; wl[0] = 8'h00; wl[1] = 8'h01;
        check_loads("D");
        chk("D_halted", -1, 8'(halt_seen), 8'd1);

        // E: reset while executing
        n_idle = 0; n_instr = 2; rst_at = 0;
        set_instr(0, 8'h10, 0, 1'b1, 8'h40, 1'b0, 1'b0);
        set_instr(1, 8'h10, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        build(); run_plan();
        wn = 1; wl[0] = 8'h00;
        check_loads("E");
        chk("E_exec_count", -1, 8'(exec_n), 8'd1);

        // randomized scenarios
        for (int s = 0; s < 40; s++) begin
            int r;
            n_idle  = $urandom_range(0, 3);
            n_instr = $urandom_range(1, 6);
            rst_at  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n_instr - 1) : -1;
            for (int j = 0; j < n_instr; j++) begin
                r = $urandom_range(0, 19);
                set_instr(j, ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom),
                          (r < 16) ? r % 4 : ((r < 18) ? TO - 1 : TO),
                          1'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom));
            end
            build(); run_plan();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
